// File: rtl/dmem_split_access.sv
// dmem_split_access: word-organised data memory behind a valid/ready
// request/response handshake, with byte/half/word loads and stores.
// Every access is range-checked, and an unknown select code is rejected.
// Load data is sign- or zero-extended and returned one cycle after accept.
//
// Optional feature macro: DMEM_MISALIGN_SPLIT_EN
//   defined   - accesses that cross a word boundary run as two word beats
//   undefined - misaligned half/word accesses are rejected with rsp_err
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset (RAM not cleared)
//   req_valid/ready request handshake; req_ready is high only when idle
//   req_we          1 = store, 0 = load
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   req_load_sel    B=000 H=001 W=010 BU=100 HU=101
//   req_store_sel   B=00 H=01 W=10
//   rsp_valid/ready response handshake; response held until rsp_ready
//   rsp_rdata       extended load data, 0 for stores and errors
//   rsp_err         access rejected (range, misalignment, bad select)
module dmem_split_access #(
  parameter int unsigned MEM_NBYTE = 1024,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_load_sel,
  input  logic [1:0]        req_store_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned BYTE_AW = $clog2(MEM_NBYTE);
  localparam int unsigned IDX_W   = BYTE_AW - 2;
  localparam int unsigned WORDS   = MEM_NBYTE / 4;

  localparam logic [2:0] LOAD_SEL_B  = 3'b000;
  localparam logic [2:0] LOAD_SEL_H  = 3'b001;
  localparam logic [2:0] LOAD_SEL_W  = 3'b010;
  localparam logic [2:0] LOAD_SEL_BU = 3'b100;
  localparam logic [2:0] LOAD_SEL_HU = 3'b101;
  localparam logic [1:0] STORE_SEL_B = 2'b00;
  localparam logic [1:0] STORE_SEL_H = 2'b01;
  localparam logic [1:0] STORE_SEL_W = 2'b10;

  localparam logic [1:0] IDLE  = 2'd0;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam logic [1:0] BEAT1 = 2'd1;
`endif
  localparam logic [1:0] RESP  = 2'd2;

  logic [31:0]       mem [0:WORDS-1];
  logic [1:0]        state;

  logic              bad_sel;
  logic [1:0]        nbm1;      // access size in bytes minus one
  logic [1:0]        off;
  logic [3:0]        bmask;
  logic              misal;
  logic              range_err;
  logic              align_err;
  logic              err;
  logic              split;
  logic [ADDR_W:0]   last;
  logic [IDX_W-1:0]  idx_a;
  logic [31:0]       rd_single;
  logic [3:0]        wmask_lo;
  logic [31:0]       wdata_lo;
  logic              accept;

`ifdef DMEM_MISALIGN_SPLIT_EN
  logic [2:0]        off_sum;
  logic [7:0]        wmask64;
  logic [63:0]       wdata64;
  logic [IDX_W-1:0]  idx_b;
  logic [IDX_W-1:0]  idx_b_q;
  logic [3:0]        wmask_hi_q;
  logic [31:0]       wdata_hi_q;
  logic              we_q;
  logic [2:0]        sel_q;
  logic [1:0]        off_q;
  logic [31:0]       word_a_q;
  logic [31:0]       rd_split;
`endif

  function automatic logic [31:0] load_ext(input logic [2:0] sel, input logic [31:0] d);
    case (sel)
      LOAD_SEL_B:  load_ext = {{24{d[7]}}, d[7:0]};
      LOAD_SEL_BU: load_ext = {24'h0, d[7:0]};
      LOAD_SEL_H:  load_ext = {{16{d[15]}}, d[15:0]};
      LOAD_SEL_HU: load_ext = {16'h0, d[15:0]};
      LOAD_SEL_W:  load_ext = d;
      default:     load_ext = '0;
    endcase
  endfunction

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;

  always_comb begin
    bad_sel = 1'b0;
    nbm1    = 2'd0;
    if (req_we) begin
      case (req_store_sel)
        STORE_SEL_B: nbm1 = 2'd0;
        STORE_SEL_H: nbm1 = 2'd1;
        STORE_SEL_W: nbm1 = 2'd3;
        default:     bad_sel = 1'b1;
      endcase
    end else begin
      case (req_load_sel)
        LOAD_SEL_B, LOAD_SEL_BU: nbm1 = 2'd0;
        LOAD_SEL_H, LOAD_SEL_HU: nbm1 = 2'd1;
        LOAD_SEL_W:              nbm1 = 2'd3;
        default:                 bad_sel = 1'b1;
      endcase
    end
    off   = req_addr[1:0];
    bmask = (nbm1 == 2'd0) ? 4'b0001 : (nbm1 == 2'd1) ? 4'b0011 : 4'b1111;
    misal = ((nbm1 == 2'd1) && off[0]) || ((nbm1 == 2'd3) && (off != 2'd0));
    // Last byte touched, one bit wider so there is no wrap to address 0;
    // non-zero address bits above the array also land here.
    last      = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, nbm1};
    range_err = (last >= (ADDR_W+1)'(MEM_NBYTE));
    idx_a     = req_addr[BYTE_AW-1:2];
    rd_single = mem[idx_a] >> {off, 3'b000};
`ifdef DMEM_MISALIGN_SPLIT_EN
    off_sum   = {1'b0, off} + {1'b0, nbm1};
    split     = off_sum[2];
    align_err = 1'b0;
    wmask64   = {4'b0000, bmask} << off;
    wdata64   = {32'h0, req_wdata} << {off, 3'b000};
    wmask_lo  = wmask64[3:0];
    wdata_lo  = wdata64[31:0];
    idx_b     = idx_a + IDX_W'(1);
    rd_split  = 32'({mem[idx_b_q], word_a_q} >> {off_q, 3'b000});
`else
    split     = 1'b0;
    align_err = misal;
    wmask_lo  = bmask << off;
    wdata_lo  = req_wdata << {off, 3'b000};
`endif
    err = bad_sel || range_err || align_err;
  end

  // Both words are range-checked before the first write, so a rejected
  // split store never writes beat 0.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (accept && req_we && !err) begin
        for (int unsigned i = 0; i < 4; i++)
          if (wmask_lo[i]) mem[idx_a][8*i +: 8] <= wdata_lo[8*i +: 8];
      end
`ifdef DMEM_MISALIGN_SPLIT_EN
      if ((state == BEAT1) && we_q) begin
        for (int unsigned i = 0; i < 4; i++)
          if (wmask_hi_q[i]) mem[idx_b_q][8*i +: 8] <= wdata_hi_q[8*i +: 8];
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (err) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end else if (split) begin
`ifdef DMEM_MISALIGN_SPLIT_EN
              idx_b_q    <= idx_b;
              wmask_hi_q <= wmask64[7:4];
              wdata_hi_q <= wdata64[63:32];
              we_q       <= req_we;
              sel_q      <= req_load_sel;
              off_q      <= off;
              word_a_q   <= mem[idx_a];
              rsp_err    <= 1'b0;
              state      <= BEAT1;
`endif
            end else begin
              rsp_err   <= 1'b0;
              rsp_rdata <= req_we ? '0 : load_ext(req_load_sel, rd_single);
              state     <= RESP;
            end
          end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        BEAT1: begin
          rsp_rdata <= we_q ? '0 : load_ext(sel_q, rd_split);
          state     <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
